// File: rtl/ddr_preload_pkg.sv
// Shared types and helpers for the DDR preload packer.
//   state_t     : controller states
//   phase_t     : write pass or readback pass
//   wpl_of      : source words per DDR line
//   line_cnt_w  : width of the line counter (holds 0..NUM_LINES)
//   BE_ALL_ONES : all-ones byte-enable pattern; the top slices its own width
//                 from the LSBs, so lines up to BE_MAX_W*8 bits are supported.
package ddr_preload_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    GAP   = 3'd3,
    READ  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    FAIL  = 3'd7
  } state_t;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } phase_t;

  localparam int BE_MAX_W = 512;
  localparam logic [BE_MAX_W-1:0] BE_ALL_ONES = '1;

  function automatic int wpl_of(input int data_w, input int word_w);
    return data_w / word_w;
  endfunction

  function automatic int line_cnt_w(input int num_lines);
    return $clog2(num_lines + 1);
  endfunction

endpackage

// File: rtl/ddr_preload_packer_line_packer.sv
// Assembles WPL = DATA_W/WORD_W source words into one DDR line.
//   clk, reset : clock, synchronous active-high reset
//   word_valid : a source word is present on word this cycle
//   word       : source word; word k of a line lands in line[k*WORD_W +: WORD_W]
//   first      : marks word 0 of a line; the rest of the line is cleared
//   line       : packed line
//   full       : all WPL words of the current line have been captured
module line_packer #(
  parameter int DATA_W = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word,
  input  logic              first,
  output logic [DATA_W-1:0] line,
  output logic              full
);
  import ddr_preload_pkg::*;

  localparam int WPL = wpl_of(DATA_W, WORD_W);
  localparam int IW  = $clog2(WPL + 1);

  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      line <= '0;
      idx  <= '0;
      full <= 1'b0;
    end else if (word_valid) begin
      if (first) begin
        line <= DATA_W'(word);
        idx  <= IW'(1);
        full <= (WPL == 1);
      end else if (idx < IW'(WPL)) begin
        line[int'(idx)*WORD_W +: WORD_W] <= word;
        idx  <= idx + IW'(1);
        full <= (idx == IW'(WPL - 1));
      end
    end
  end

endmodule

// File: rtl/ddr_preload_packer.sv
// Preloads NUM_LINES DDR lines from a 32-bit pattern source, then optionally
// reads every line back and compares it with a freshly packed copy.
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle pulse starting a preload (ignored while busy)
//   src_addr     : source word address (registered); src_data returns 1 cycle later
//   src_data     : source word
//   wr_req/wr_addr/wr_data/wr_be, wr_ack : line write request, held until wr_ack
//   rd_req/rd_addr, rd_valid/rd_data     : line read request, held until rd_valid
//   busy         : a preload or verify is in progress
//   setup_done   : everything written (and verified, if enabled); held
//   verify_fail  : readback mismatch seen; sticky until next start
//   err_line     : line index of the first mismatch
module ddr_preload_packer
  import ddr_preload_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 25,
  parameter int SRC_AW     = 10,
  parameter int NUM_LINES  = 4,
  parameter int BASE_ADDR  = 0,
  parameter int GAP_CYCLES = 30,
  parameter int VERIFY_EN  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [SRC_AW-1:0]   src_addr,
  input  logic [WORD_W-1:0]   src_data,
  output logic                wr_req,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_be,
  input  logic                wr_ack,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_valid,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                setup_done,
  output logic                verify_fail,
  output logic [ADDR_W-1:0]   err_line
);

  localparam int WPL      = wpl_of(DATA_W, WORD_W);
  localparam int LCW      = line_cnt_w(NUM_LINES);
  localparam int FW       = $clog2(WPL + 1);
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int BE_W     = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_LINE = BE_ALL_ONES[BE_W-1:0];

  state_t            state;
  phase_t            phase;
  logic [LCW-1:0]    line;
  logic [FW-1:0]     fetch_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              vld_p1;
  logic              first_p1;
  logic [DATA_W-1:0] rd_line_p1;
  logic [DATA_W-1:0] pk_line;
  logic              pk_full;
  logic              last_line;
  logic              wr_line_done;
  logic [ADDR_W-1:0] line_addr;

  function automatic logic [SRC_AW-1:0] src_word_addr(input logic [LCW-1:0] n,
                                                      input logic [FW-1:0]  k);
    return SRC_AW'(int'(n) * WPL + int'(k));
  endfunction

  assign last_line    = (line == LCW'(NUM_LINES - 1));
  assign line_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(line);
  assign wr_line_done = (state == WRITE && wr_ack && GAP_CYCLES == 0) ||
                        (state == GAP && gap_cnt == GW'(GAP_LAST));
  assign busy         = !(state == IDLE || state == DONE || state == FAIL);
  assign wr_data      = pk_line;
  assign wr_be        = wr_req ? BE_LINE : '0;

  // ---- stage p0 -> p1: source word returns one cycle after its address ----
  line_packer #(
    .DATA_W(DATA_W),
    .WORD_W(WORD_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .word_valid(vld_p1),
    .word      (src_data),
    .first     (first_p1),
    .line      (pk_line),
    .full      (pk_full)
  );

  // ---- stage p1: readback line held for the CHECK compare ----
  always_ff @(posedge clk) begin
    if (state == READ && rd_valid) rd_line_p1 <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= WR;
      line        <= '0;
      fetch_cnt   <= '0;
      gap_cnt     <= '0;
      src_addr    <= '0;
      vld_p1      <= 1'b0;
      first_p1    <= 1'b0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      setup_done  <= 1'b0;
      verify_fail <= 1'b0;
      err_line    <= '0;
    end else begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            line        <= '0;
            phase       <= WR;
            setup_done  <= 1'b0;
            verify_fail <= 1'b0;
            err_line    <= '0;
            state       <= FETCH;
            fetch_cnt   <= '0;
            src_addr    <= src_word_addr('0, '0);
          end
        end
        FETCH: begin
          // Address k goes out in cycle k; its word is captured in cycle k+1.
          if (fetch_cnt < FW'(WPL)) begin
            vld_p1   <= 1'b1;
            first_p1 <= (fetch_cnt == '0);
          end
          if (fetch_cnt == FW'(WPL)) begin
            if (phase == WR) begin
              state   <= WRITE;
              wr_req  <= 1'b1;
              wr_addr <= line_addr;
            end else begin
              state   <= READ;
              rd_req  <= 1'b1;
              rd_addr <= line_addr;
            end
          end else begin
            fetch_cnt <= fetch_cnt + FW'(1);
            if (fetch_cnt < FW'(WPL - 1))
              src_addr <= src_word_addr(line, fetch_cnt + FW'(1));
          end
        end
        WRITE: begin
          if (wr_ack) begin
            wr_req  <= 1'b0;
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: gap_cnt <= gap_cnt + GW'(1);
        READ: begin
          if (rd_valid) begin
            rd_req <= 1'b0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (!pk_full || rd_line_p1 != pk_line) begin
            verify_fail <= 1'b1;
            err_line    <= ADDR_W'(line);
            state       <= FAIL;
          end else if (last_line) begin
            setup_done <= 1'b1;
            state      <= DONE;
          end else begin
            line      <= line + LCW'(1);
            state     <= FETCH;
            fetch_cnt <= '0;
            src_addr  <= src_word_addr(line + LCW'(1), '0);
          end
        end
        default: state <= IDLE;
      endcase

      // End of a line's write (after the gap, or straight from WRITE when
      // there is no gap); overrides the GAP/WRITE transitions above.
      if (wr_line_done) begin
        if (!last_line) begin
          line      <= line + LCW'(1);
          state     <= FETCH;
          fetch_cnt <= '0;
          src_addr  <= src_word_addr(line + LCW'(1), '0);
        end else if (VERIFY_EN != 0) begin
          line      <= '0;
          phase     <= RD;
          state     <= FETCH;
          fetch_cnt <= '0;
          src_addr  <= src_word_addr('0, '0);
        end else begin
          setup_done <= 1'b1;
          state      <= DONE;
        end
      end
    end
  end

endmodule

// File: doc/ddr_preload_packer.md
Name: ddr_preload_packer

Overview:
- Parametrised successor to the 256-bit DDR setup block. It preloads NUM_LINES wide DDR lines from a 32-bit pattern source (sync ROM/RAM) into DDR.
- Packs DATA_W/WORD_W source words per line and issues one write per line over the existing wr_rq/action_done-style request interface.
- New over the previous generation: generic widths/depth, a start trigger, a configurable inter-write gap, and an optional readback-verify pass with error reporting.
- Sits between the pattern ROM and the avalon_mm_ddr request port, in the clk domain.

Parameters:
DATA_W, 256, DDR line width in bits; must be a multiple of WORD_W.
WORD_W, 32, source word width in bits.
ADDR_W, 25, DDR line address width.
SRC_AW, 10, source address width.
NUM_LINES, 4, lines written (1..2**ADDR_W).
BASE_ADDR, 0, DDR address of line 0.
GAP_CYCLES, 30, idle cycles after each completed write (0 allowed).
VERIFY_EN, 1, 1 = readback-compare pass after the write pass.

Ports:
clk  in  1  clock.
reset  in  1  reset; synchronous, active-high.
start  in  1  one-cycle pulse that begins a preload; ignored while busy.
src_addr  out  SRC_AW  source word address.
src_data  in  WORD_W  source word; valid 1 cycle after src_addr.
wr_req  out  1  write request; held until wr_ack.
wr_addr  out  ADDR_W  write line address.
wr_data  out  DATA_W  packed line.
wr_be  out  DATA_W/8  byte enables; all ones whenever wr_req is high.
wr_ack  in  1  one-cycle write completion.
rd_req  out  1  read request; held until rd_valid.
rd_addr  out  ADDR_W  read line address.
rd_valid  in  1  one-cycle read data valid.
rd_data  in  DATA_W  read line.
busy  out  1  FSM not in IDLE, DONE or FAIL.
setup_done  out  1  preload (and verify, if enabled) passed; held.
verify_fail  out  1  mismatch detected; sticky.
err_line  out  ADDR_W  line index (not address) of the first mismatch.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Reset mid-operation abandons the transfer; a later wr_ack or rd_valid is ignored.
- Constants: WPL = DATA_W/WORD_W. Source address of word k in line n = n*WPL + k, truncated to SRC_AW.
- Packing: word k goes to line[k*WORD_W +: WORD_W], so word 0 lands in the LSBs. The pack register is cleared at the start of each line.
- FSM states: IDLE, FETCH, WRITE, GAP, READ, CHECK, DONE, FAIL.
- IDLE / DONE / FAIL --start--> FETCH. On this transition: line = 0, phase = WR, setup_done = 0, verify_fail = 0, err_line = 0.
- FETCH: drive src_addr for k = 0..WPL-1 on consecutive cycles and capture src_data one cycle later (pipelined). Lasts WPL+1 cycles. Exit to WRITE if phase = WR, else to READ.
- WRITE: wr_req = 1 with stable wr_addr = BASE_ADDR+line, wr_data and wr_be. On wr_ack: drop wr_req the next cycle and go to GAP.
- GAP: count GAP_CYCLES cycles (skipped when 0), then:
  - if line < NUM_LINES-1: line++, go to FETCH;
  - else if VERIFY_EN: line = 0, phase = RD, go to FETCH;
  - else go to DONE.
- READ: rd_req = 1 with rd_addr = BASE_ADDR+line. On rd_valid: register rd_data and go to CHECK.
- CHECK (1 cycle):
  - mismatch: verify_fail = 1, err_line = line, go to FAIL;
  - match, not the last line: line++, go to FETCH;
  - match, last line: go to DONE.
- DONE: setup_done = 1, held until reset or start.
- FAIL: setup_done stays 0, verify_fail is held.
- Simultaneous events:
  - wr_ack or rd_valid in any state other than WRITE/READ is ignored.
  - start coinciding with reset: reset wins.
  - wr_ack in the same cycle wr_req first rises is accepted.
- Minimum latency, write pass: NUM_LINES * (WPL+1 + 1 + ack_lat + GAP_CYCLES) cycles.
- Address wrap: the line counter is a clog2(NUM_LINES+1)-bit counter. The BASE_ADDR+line sum is computed at ADDR_W bits and wraps modulo 2**ADDR_W.

Decomposition:
- Package ddr_preload_pkg holds:
  - the state_t enum (8 states) and phase_t (WR, RD);
  - localparam functions for WPL and the line counter width;
  - a default all-ones byte-enable constant.
- Sub-module line_packer (one instance): takes word_valid, word, first and DATA_W/WORD_W parameters; outputs the packed line plus a full flag after WPL words.

Test Plan:
- Defaults; ROM[i] = 32'hA000_0000+i; wr_ack 3 cycles after wr_req → exactly 4 writes:
  - addr 0..3;
  - line 1 word 0 = 32'hA000_0008 at bits [31:0];
  - line 1 word 7 = 32'hA000_000F at bits [255:224];
  - verify passes, setup_done = 1, verify_fail = 0.
- Memory model corrupts line 2 bit 100 → verify_fail = 1, err_line = 2, setup_done = 0, busy = 0, no read issued for line 3.
- DATA_W = 128, NUM_LINES = 3, GAP_CYCLES = 0, VERIFY_EN = 0 → 3 writes of 4 words each, line 2 = {ROM[11], ROM[10], ROM[9], ROM[8]}, setup_done with no rd_req ever.
- reset asserted during the second WRITE with wr_req high → next cycle all outputs 0; a late wr_ack is ignored; a new start restarts from line 0, addr BASE_ADDR.
- start pulsed while busy, and again after DONE → the first is ignored; the second clears setup_done and repeats the full sequence.
- wr_ack held off for 1000 cycles → wr_req, wr_addr and wr_data are stable throughout; wr_be = all ones.
